// File: rtl/pipo_load_arbiter_pkg.sv
// Shared encodings and default parameters for the PIPO load arbiter.
package pipo_load_arbiter_pkg;

  localparam int unsigned DEF_N_REQ    = 4;
  localparam int unsigned DEF_WIDTH    = 4;
  localparam int unsigned DEF_HOLD_CYC = 2;
  localparam int unsigned OWNER_W      = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/pipo_load_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after (ptr+1) mod N_REQ.
module rr_pick
  import pipo_load_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ
) (
  input  logic [N_REQ-1:0]   req,
  input  logic [OWNER_W-1:0] ptr,
  output logic [N_REQ-1:0]   onehot,
  output logic [OWNER_W-1:0] idx,
  output logic               any
);

  // Scan from the slot after the last winner; the first hit wins.
  always_comb begin
    int unsigned pos;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    pos    = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pos = (32'(ptr) + 32'd1 + k) % N_REQ;
      if (!any && (((req >> pos) & N_REQ'(1)) != N_REQ'(0))) begin
        any    = 1'b1;
        idx    = OWNER_W'(pos);
        onehot = N_REQ'(1) << pos;
      end
    end
  end

endmodule

// File: rtl/pipo_load_arbiter.sv
// Arbitrates N_REQ requesters onto one shared PIPO register, one load at a time.
module pipo_load_arbiter
  import pipo_load_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ    = DEF_N_REQ,
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned HOLD_CYC = DEF_HOLD_CYC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]         gnt,
  output logic                     load,
  output logic [WIDTH-1:0]         d,
  output logic [OWNER_W-1:0]       owner,
  output logic                     owner_valid,
  output logic                     busy
);

  localparam int unsigned CNT_W = $clog2(HOLD_CYC + 1);

  arb_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [OWNER_W-1:0]  last_q, last_d;
  logic [N_REQ-1:0]    gnt_d;
  logic                load_d;
  logic [WIDTH-1:0]    d_d;
  logic [OWNER_W-1:0]  owner_d;
  logic                owner_valid_d;
  logic                busy_d;

  logic [N_REQ-1:0]    pick_onehot;
  logic [OWNER_W-1:0]  pick_idx;
  logic                pick_any;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (req),
    .ptr    (last_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Next-state and next-output logic; requests are only looked at in IDLE.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_d        = last_q;
    gnt_d         = '0;
    load_d        = 1'b0;
    d_d           = d;
    owner_d       = owner;
    owner_valid_d = owner_valid;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          last_d  = pick_idx;
          gnt_d   = pick_onehot;
          load_d  = 1'b1;
          d_d     = WIDTH'(req_data >> (32'(pick_idx) * WIDTH));
        end
      end
      GRANT: begin
        state_d       = HOLD;
        cnt_d         = CNT_W'(1);
        owner_d       = last_q;
        owner_valid_d = 1'b1;
      end
      HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYC)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= OWNER_W'(N_REQ - 1);
      gnt         <= '0;
      load        <= 1'b0;
      d           <= '0;
      owner       <= '0;
      owner_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      gnt         <= gnt_d;
      load        <= load_d;
      d           <= d_d;
      owner       <= owner_d;
      owner_valid <= owner_valid_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Directed self-checking bench for pipo_load_arbiter.
module tb_pipo_load_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] req_data;
  logic [3:0]  gnt;
  logic        load;
  logic [3:0]  d;
  logic [2:0]  owner;
  logic        owner_valid;
  logic        busy;

  logic [3:0]  q;
  logic        rst_at_edge = 1'b1;
  logic [3:0]  d_prev = 4'h0;

  int n_cmp = 0;
  int n_err = 0;

  pipo_load_arbiter #(.N_REQ(4), .WIDTH(4), .HOLD_CYC(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .load        (load),
    .d           (d),
    .owner       (owner),
    .owner_valid (owner_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Shared register fed by the arbiter.
  always @(posedge clk) begin
    if (rst) q <= 4'h0;
    else if (load) q <= d;
  end

  always @(posedge clk) rst_at_edge <= rst;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Continuous properties sampled mid-cycle.
  always @(negedge clk) begin
    check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    check("load_eq_gnt", 32'(load), 32'(|gnt));
    if (!load && !rst_at_edge) check("d_stable", 32'(d), 32'(d_prev));
    d_prev = d;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_gnt;
    rst      = 1'b1;
    req      = 4'b1111;
    req_data = 16'h4321;

    // Reset held two cycles with all requests high.
    for (int i = 0; i < 2; i++) begin
      step(1);
      check("rst_gnt", 32'(gnt), 0);
      check("rst_load", 32'(load), 0);
      check("rst_d", 32'(d), 0);
      check("rst_owner_valid", 32'(owner_valid), 0);
      check("rst_busy", 32'(busy), 0);
    end
    rst = 1'b0;
    req = 4'b0000;
    step(1);
    check("idle_busy", 32'(busy), 0);

    // Single request from requester 2.
    req      = 4'b0100;
    req_data = {4'h3, 4'b1010, 4'h5, 4'h6};
    step(1);
    check("single_gnt", 32'(gnt), 'h4);
    check("single_load", 32'(load), 1);
    check("single_d", 32'(d), 'ha);
    check("single_busy", 32'(busy), 1);
    check("single_ov_pre", 32'(owner_valid), 0);
    req = 4'b0000;
    step(1);
    check("single_q", 32'(q), 'ha);
    check("single_owner", 32'(owner), 2);
    check("single_ov", 32'(owner_valid), 1);
    check("single_hold_gnt", 32'(gnt), 0);
    step(2);
    check("single_back_idle", 32'(busy), 0);

    // Fairness from a fresh pointer, all requesters held high.
    rst = 1'b1;
    step(1);
    rst      = 1'b0;
    req      = 4'b1111;
    req_data = 16'h8421;
    step(1);
    for (int k = 0; k < 5; k++) begin
      exp_gnt = 1 << (k % 4);
      check("fair_gnt", 32'(gnt), 32'(exp_gnt));
      check("fair_d", 32'(d), 32'(exp_gnt));
      if (k == 4) break;
      for (int j = 0; j < 3; j++) begin
        step(1);
        check("fair_gap_gnt", 32'(gnt), 0);
      end
      step(1);
    end
    req = 4'b0000;

    // Requests during HOLD are ignored; a withdrawn one never wins.
    step(1);
    req = 4'b0010;
    step(1);
    check("ign_hold_gnt", 32'(gnt), 0);
    req = 4'b1000;
    step(1);
    check("ign_idle_gnt", 32'(gnt), 0);
    check("ign_idle_busy", 32'(busy), 0);
    step(1);
    check("late_gnt", 32'(gnt), 'h8);
    check("late_d", 32'(d), 'h8);
    req = 4'b0000;
    step(1);
    check("late_owner", 32'(owner), 3);

    // Reset in HOLD after a grant to requester 1.
    step(2);
    req = 4'b0010;
    step(1);
    check("r1_gnt", 32'(gnt), 'h2);
    req = 4'b0000;
    step(1);
    check("r1_owner", 32'(owner), 1);
    rst = 1'b1;
    step(1);
    check("abort_gnt", 32'(gnt), 0);
    check("abort_load", 32'(load), 0);
    check("abort_d", 32'(d), 0);
    check("abort_owner", 32'(owner), 0);
    check("abort_ov", 32'(owner_valid), 0);
    check("abort_busy", 32'(busy), 0);
    rst = 1'b0;
    req = 4'b0011;
    step(1);
    check("post_rst_gnt", 32'(gnt), 'h1);
    check("post_rst_d", 32'(d), 'h1);
    req = 4'b0000;
    step(4);
    check("end_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
